// File: rtl/openofdm_rx_pkt_sequencer.sv
// Packet-level sequencer for the OFDM receive chain: tracks each reception, enforces
// an inactivity timeout, issues a bounded core re-arm reset and keeps packet statistics.
module openofdm_rx_pkt_sequencer #(
  parameter int TIMEOUT_WIDTH = 24,
  parameter int RST_CYCLES    = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  input  logic                     sw_abort,
  input  logic                     long_preamble_detected,
  input  logic                     pkt_header_valid_strobe,
  input  logic                     pkt_header_valid,
  input  logic                     ht_unsupport,
  input  logic                     byte_out_strobe,
  input  logic                     fcs_out_strobe,
  input  logic                     fcs_ok,
  output logic                     core_rst,
  output logic                     busy,
  output logic [2:0]               ctrl_state,
  output logic [2:0]               last_cause,
  output logic [CNT_WIDTH-1:0]     cnt_fcs_ok,
  output logic [CNT_WIDTH-1:0]     cnt_fcs_bad,
  output logic [CNT_WIDTH-1:0]     cnt_hdr_reject,
  output logic [CNT_WIDTH-1:0]     cnt_timeout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    PAYLOAD = 3'd2,
    DONE    = 3'd3,
    FLUSH   = 3'd4
  } state_t;

  localparam int RC_WIDTH = $clog2(RST_CYCLES + 1);
  localparam logic [RC_WIDTH-1:0] RC_LOAD = RC_WIDTH'(RST_CYCLES);

  localparam logic [2:0] CAUSE_DONE    = 3'd1;
  localparam logic [2:0] CAUSE_REJECT  = 3'd2;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd3;
  localparam logic [2:0] CAUSE_ABORT   = 3'd4;

  state_t                   state, next_state;
  logic [TIMEOUT_WIDTH-1:0] timer;
  logic [RC_WIDTH-1:0]      rst_cnt;
  logic [2:0]               flush_cause;
  logic                     timer_load;
  logic                     timer_expired;
  logic                     ev_hdr_reject, ev_fcs_ok, ev_fcs_bad, ev_timeout;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Abort outranks packet strobes, which outrank timer expiry; a timer value of
  // zero never reaches one, which is what makes cfg_timeout=0 disable the timeout.
  always_comb begin
    next_state    = state;
    flush_cause   = 3'd0;
    timer_load    = 1'b0;
    ev_hdr_reject = 1'b0;
    ev_fcs_ok     = 1'b0;
    ev_fcs_bad    = 1'b0;
    ev_timeout    = 1'b0;
    timer_expired = (timer == TIMEOUT_WIDTH'(1));
    case (state)
      IDLE: begin
        if (sw_abort) begin
          next_state  = FLUSH;
          flush_cause = CAUSE_ABORT;
        end else if (enable && long_preamble_detected) begin
          next_state = SYNC;
          timer_load = 1'b1;
        end
      end
      SYNC: begin
        if (sw_abort) begin
          next_state  = FLUSH;
          flush_cause = CAUSE_ABORT;
        end else if (pkt_header_valid_strobe) begin
          if (pkt_header_valid && !ht_unsupport) begin
            next_state = PAYLOAD;
            timer_load = 1'b1;
          end else begin
            next_state    = FLUSH;
            flush_cause   = CAUSE_REJECT;
            ev_hdr_reject = 1'b1;
          end
        end else if (timer_expired) begin
          next_state  = FLUSH;
          flush_cause = CAUSE_TIMEOUT;
          ev_timeout  = 1'b1;
        end
      end
      PAYLOAD: begin
        if (sw_abort) begin
          next_state  = FLUSH;
          flush_cause = CAUSE_ABORT;
        end else if (fcs_out_strobe) begin
          next_state = DONE;
          ev_fcs_ok  = fcs_ok;
          ev_fcs_bad = !fcs_ok;
        end else if (byte_out_strobe) begin
          timer_load = 1'b1;
        end else if (timer_expired) begin
          next_state  = FLUSH;
          flush_cause = CAUSE_TIMEOUT;
          ev_timeout  = 1'b1;
        end
      end
      DONE: begin
        next_state  = FLUSH;
        flush_cause = sw_abort ? CAUSE_ABORT : CAUSE_DONE;
      end
      FLUSH: begin
        if (!sw_abort && rst_cnt == RC_WIDTH'(1)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    ctrl_state = state;
  end

  // core_rst mirrors the registered FLUSH state; an abort inside FLUSH restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer          <= '0;
      rst_cnt        <= '0;
      core_rst       <= 1'b0;
      last_cause     <= 3'd0;
      cnt_fcs_ok     <= '0;
      cnt_fcs_bad    <= '0;
      cnt_hdr_reject <= '0;
      cnt_timeout    <= '0;
    end else begin
      core_rst <= (next_state == FLUSH);
      if (timer_load)
        timer <= cfg_timeout;
      else if ((state == SYNC || state == PAYLOAD) && timer != '0)
        timer <= timer - TIMEOUT_WIDTH'(1);
      if (next_state == FLUSH && (state != FLUSH || sw_abort))
        rst_cnt <= RC_LOAD;
      else if (state == FLUSH && rst_cnt != '0)
        rst_cnt <= rst_cnt - RC_WIDTH'(1);
      if (state != FLUSH && next_state == FLUSH)
        last_cause <= flush_cause;
      if (ev_fcs_ok)     cnt_fcs_ok     <= sat_inc(cnt_fcs_ok);
      if (ev_fcs_bad)    cnt_fcs_bad    <= sat_inc(cnt_fcs_bad);
      if (ev_hdr_reject) cnt_hdr_reject <= sat_inc(cnt_hdr_reject);
      if (ev_timeout)    cnt_timeout    <= sat_inc(cnt_timeout);
    end
  end

endmodule

// File: tb/tb_openofdm_rx_pkt_sequencer.sv
// Bench for openofdm_rx_pkt_sequencer: two instances (16-bit and 2-bit counters) share
// one stimulus and are checked every cycle against a deadline-based packet model.
module tb_openofdm_rx_pkt_sequencer;

  localparam int TW  = 24;
  localparam int RC  = 4;
  localparam int CW  = 16;
  localparam int CW2 = 2;

  localparam logic [7:0] S_PRE    = 8'h01;
  localparam logic [7:0] S_HDR    = 8'h02;
  localparam logic [7:0] S_HVALID = 8'h04;
  localparam logic [7:0] S_HT     = 8'h08;
  localparam logic [7:0] S_BYTE   = 8'h10;
  localparam logic [7:0] S_FCS    = 8'h20;
  localparam logic [7:0] S_FOK    = 8'h40;
  localparam logic [7:0] S_ABORT  = 8'h80;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [TW-1:0] cfg_timeout = '0;
  logic          sw_abort = 1'b0, long_preamble_detected = 1'b0;
  logic          pkt_header_valid_strobe = 1'b0, pkt_header_valid = 1'b0, ht_unsupport = 1'b0;
  logic          byte_out_strobe = 1'b0, fcs_out_strobe = 1'b0, fcs_ok = 1'b0;

  logic          core_rst_a, busy_a, core_rst_b, busy_b;
  logic [2:0]    ctrl_state_a, last_cause_a, ctrl_state_b, last_cause_b;
  logic [CW-1:0] cnt_fcs_ok_a, cnt_fcs_bad_a, cnt_hdr_reject_a, cnt_timeout_a;
  logic [CW2-1:0] cnt_fcs_ok_b, cnt_fcs_bad_b, cnt_hdr_reject_b, cnt_timeout_b;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  always #5 clock = ~clock;

  openofdm_rx_pkt_sequencer #(.TIMEOUT_WIDTH(TW), .RST_CYCLES(RC), .CNT_WIDTH(CW)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .cfg_timeout(cfg_timeout),
    .sw_abort(sw_abort), .long_preamble_detected(long_preamble_detected),
    .pkt_header_valid_strobe(pkt_header_valid_strobe), .pkt_header_valid(pkt_header_valid),
    .ht_unsupport(ht_unsupport), .byte_out_strobe(byte_out_strobe),
    .fcs_out_strobe(fcs_out_strobe), .fcs_ok(fcs_ok),
    .core_rst(core_rst_a), .busy(busy_a), .ctrl_state(ctrl_state_a), .last_cause(last_cause_a),
    .cnt_fcs_ok(cnt_fcs_ok_a), .cnt_fcs_bad(cnt_fcs_bad_a),
    .cnt_hdr_reject(cnt_hdr_reject_a), .cnt_timeout(cnt_timeout_a));

  openofdm_rx_pkt_sequencer #(.TIMEOUT_WIDTH(TW), .RST_CYCLES(RC), .CNT_WIDTH(CW2)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .cfg_timeout(cfg_timeout),
    .sw_abort(sw_abort), .long_preamble_detected(long_preamble_detected),
    .pkt_header_valid_strobe(pkt_header_valid_strobe), .pkt_header_valid(pkt_header_valid),
    .ht_unsupport(ht_unsupport), .byte_out_strobe(byte_out_strobe),
    .fcs_out_strobe(fcs_out_strobe), .fcs_ok(fcs_ok),
    .core_rst(core_rst_b), .busy(busy_b), .ctrl_state(ctrl_state_b), .last_cause(last_cause_b),
    .cnt_fcs_ok(cnt_fcs_ok_b), .cnt_fcs_bad(cnt_fcs_bad_b),
    .cnt_hdr_reject(cnt_hdr_reject_b), .cnt_timeout(cnt_timeout_b));

  // Model: unbounded event counts (saturated only when compared), an absolute
  // cycle deadline for inactivity and an absolute cycle at which FLUSH ends.
  longint cyc = 0;
  longint m_deadline = -1;
  longint m_flush_end = 0;
  int m_state = 0, m_cause = 0;
  int m_ok = 0, m_bad = 0, m_rej = 0, m_to = 0;

  function automatic longint arm_deadline(longint now, longint limit);
    return (limit == 0) ? -1 : now + limit;
  endfunction

  function automatic longint sat(longint v, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_state = 0; m_cause = 0; m_ok = 0; m_bad = 0; m_rej = 0; m_to = 0;
      m_deadline = -1;
    end else begin
      cyc = cyc + 1;
      case (m_state)
        0: if (sw_abort) begin m_state = 4; m_cause = 4; m_flush_end = cyc + RC; end
           else if (enable && long_preamble_detected) begin
             m_state = 1; m_deadline = arm_deadline(cyc, longint'(cfg_timeout));
           end
        1: if (sw_abort) begin m_state = 4; m_cause = 4; m_flush_end = cyc + RC; end
           else if (pkt_header_valid_strobe) begin
             if (pkt_header_valid && !ht_unsupport) begin
               m_state = 2; m_deadline = arm_deadline(cyc, longint'(cfg_timeout));
             end else begin
               m_rej++; m_state = 4; m_cause = 2; m_flush_end = cyc + RC;
             end
           end else if (cyc == m_deadline) begin
             m_to++; m_state = 4; m_cause = 3; m_flush_end = cyc + RC;
           end
        2: if (sw_abort) begin m_state = 4; m_cause = 4; m_flush_end = cyc + RC; end
           else if (fcs_out_strobe) begin
             if (fcs_ok) m_ok++; else m_bad++;
             m_state = 3;
           end else if (byte_out_strobe) m_deadline = arm_deadline(cyc, longint'(cfg_timeout));
           else if (cyc == m_deadline) begin
             m_to++; m_state = 4; m_cause = 3; m_flush_end = cyc + RC;
           end
        3: begin m_state = 4; m_cause = sw_abort ? 4 : 1; m_flush_end = cyc + RC; end
        default: if (sw_abort) m_flush_end = cyc + RC;
                 else if (cyc == m_flush_end) m_state = 0;
      endcase
    end
  end

  task automatic check_output(input string name, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic compare_all();
    check_output("a.ctrl_state", ctrl_state_a, m_state);
    check_output("a.busy", busy_a, (m_state != 0));
    check_output("a.core_rst", core_rst_a, (m_state == 4));
    check_output("a.last_cause", last_cause_a, m_cause);
    check_output("a.cnt_fcs_ok", cnt_fcs_ok_a, sat(m_ok, CW));
    check_output("a.cnt_fcs_bad", cnt_fcs_bad_a, sat(m_bad, CW));
    check_output("a.cnt_hdr_reject", cnt_hdr_reject_a, sat(m_rej, CW));
    check_output("a.cnt_timeout", cnt_timeout_a, sat(m_to, CW));
    check_output("b.ctrl_state", ctrl_state_b, m_state);
    check_output("b.core_rst", core_rst_b, (m_state == 4));
    check_output("b.cnt_fcs_ok", cnt_fcs_ok_b, sat(m_ok, CW2));
    check_output("b.cnt_fcs_bad", cnt_fcs_bad_b, sat(m_bad, CW2));
    check_output("b.cnt_hdr_reject", cnt_hdr_reject_b, sat(m_rej, CW2));
    check_output("b.cnt_timeout", cnt_timeout_b, sat(m_to, CW2));
  endtask

  task automatic drive(input logic [7:0] v);
    long_preamble_detected  = v[0];
    pkt_header_valid_strobe = v[1];
    pkt_header_valid        = v[2];
    ht_unsupport            = v[3];
    byte_out_strobe         = v[4];
    fcs_out_strobe          = v[5];
    fcs_ok                  = v[6];
    sw_abort                = v[7];
  endtask

  task automatic apply_stimulus(input logic [7:0] v);
    @(negedge clock);
    drive(v);
  endtask

  // first_hi is the number of cycles after the last applied input at which core_rst
  // is first seen high; an abort is injected on relative cycle abort_at (if >= 0).
  task automatic run_until_idle(input int abort_at, input int max_cyc,
                                output int first_hi, output int hi_cnt);
    bit done;
    done = 1'b0; first_hi = -1; hi_cnt = 0;
    for (int j = 0; j < max_cyc && !done; j++) begin
      @(negedge clock);
      if (core_rst_a) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = j + 1;
      end else if (hi_cnt > 0 && ctrl_state_a == 3'd0) done = 1'b1;
      drive((j == abort_at) ? S_ABORT : 8'h00);
    end
    check_output("reach_idle_in_bound", done, 1);
  endtask

  task automatic start_packet();
    apply_stimulus(S_PRE);
    apply_stimulus(S_HDR | S_HVALID);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fh, hc;
    fork
      forever begin
        @(negedge clock);
        if (checking) compare_all();
      end
    join_none

    repeat (3) @(negedge clock);
    checking = 1'b1;
    check_output("reset_state", ctrl_state_a, 0);
    check_output("reset_core_rst", core_rst_a, 0);
    check_output("reset_cnt_fcs_ok", cnt_fcs_ok_a, 0);
    reset = 1'b0;
    enable = 1'b1;

    $display("[TB] good packet");
    cfg_timeout = 1000;
    start_packet();
    check_output("sync_entry", ctrl_state_a, 1);
    apply_stimulus(8'h00);
    check_output("payload_entry", ctrl_state_a, 2);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(S_BYTE);
      repeat (49) apply_stimulus(8'h00);
    end
    check_output("payload_hold", ctrl_state_a, 2);
    apply_stimulus(S_FCS | S_FOK);
    run_until_idle(-1, 50, fh, hc);
    check_output("good_rst_start", fh, 2);
    check_output("good_rst_len", hc, 4);
    check_output("good_cnt_fcs_ok", cnt_fcs_ok_a, 1);
    check_output("good_last_cause", last_cause_a, 1);

    $display("[TB] header reject");
    apply_stimulus(S_PRE);
    apply_stimulus(S_HDR | S_HVALID | S_HT);
    run_until_idle(-1, 50, fh, hc);
    check_output("reject_rst_start", fh, 1);
    check_output("reject_cnt", cnt_hdr_reject_a, 1);
    check_output("reject_cause", last_cause_a, 2);
    apply_stimulus(S_PRE);
    apply_stimulus(S_HDR);
    run_until_idle(-1, 50, fh, hc);
    check_output("reject2_rst_start", fh, 1);
    check_output("reject2_cnt", cnt_hdr_reject_a, 2);

    // The expiry decision falls on the edge 100 cycles after the last byte is
    // sampled, so FLUSH is observed on the 101st sample after that strobe.
    $display("[TB] timeout");
    cfg_timeout = 100;
    start_packet();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) repeat (4) apply_stimulus(8'h00);
      apply_stimulus(S_BYTE);
    end
    run_until_idle(-1, 400, fh, hc);
    check_output("timeout_flush_at", fh, 101);
    check_output("timeout_cnt", cnt_timeout_a, 1);
    check_output("timeout_cause", last_cause_a, 3);

    $display("[TB] timeout disabled");
    cfg_timeout = 0;
    start_packet();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(S_BYTE);
      repeat (4) apply_stimulus(8'h00);
    end
    repeat (3000) apply_stimulus(8'h00);
    check_output("no_timeout_state", ctrl_state_a, 2);
    apply_stimulus(S_ABORT);
    run_until_idle(-1, 50, fh, hc);
    check_output("abort_rst_len", hc, 4);
    check_output("abort_cause", last_cause_a, 4);

    $display("[TB] fcs on expiry cycle");
    cfg_timeout = 100;
    start_packet();
    repeat (99) apply_stimulus(8'h00);
    apply_stimulus(S_FCS);
    run_until_idle(-1, 50, fh, hc);
    check_output("expiry_fcs_done_first", fh, 2);
    check_output("expiry_fcs_bad", cnt_fcs_bad_a, 1);
    check_output("expiry_timeout_same", cnt_timeout_a, 1);

    $display("[TB] abort with fcs");
    start_packet();
    apply_stimulus(S_BYTE);
    apply_stimulus(S_ABORT | S_FCS | S_FOK);
    run_until_idle(-1, 50, fh, hc);
    check_output("abort_fcs_flush_first", fh, 1);
    check_output("abort_fcs_ok_same", cnt_fcs_ok_a, 1);
    check_output("abort_fcs_cause", last_cause_a, 4);

    $display("[TB] abort during flush");
    start_packet();
    apply_stimulus(S_BYTE);
    apply_stimulus(S_ABORT);
    run_until_idle(1, 50, fh, hc);
    check_output("flush_extend_len", hc, 6);

    $display("[TB] saturation");
    for (int p = 0; p < 5; p++) begin
      start_packet();
      apply_stimulus(S_BYTE);
      apply_stimulus(S_FCS | S_FOK);
      run_until_idle(-1, 50, fh, hc);
    end
    check_output("sat_b_cnt_fcs_ok", cnt_fcs_ok_b, 3);
    check_output("sat_a_cnt_fcs_ok", cnt_fcs_ok_a, 6);

    $display("[TB] reset mid payload");
    start_packet();
    apply_stimulus(S_BYTE);
    @(negedge clock);
    drive(8'h00);
    #2 reset = 1'b1;
    #1;
    check_output("rst_mid_state", ctrl_state_a, 0);
    check_output("rst_mid_busy", busy_a, 0);
    check_output("rst_mid_core_rst", core_rst_a, 0);
    check_output("rst_mid_cnt_fcs_ok", cnt_fcs_ok_a, 0);
    repeat (3) apply_stimulus(8'h00);
    reset = 1'b0;
    repeat (3) apply_stimulus(8'h00);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
